ascii2hex_accum: RTL

ASCII2HEX_ACCUM -- requirements
Module: ascii2hex_accum

---
 rtl/ascii2hex_accum.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ascii2hex_accum.sv
// ASCII hex-line accumulator: collects hex digits up to a CR and emits the word.
// Optional macro ASCII2HEX_LOWER_EN also accepts lowercase a-f as digits.
module ascii2hex_accum #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              in_char,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*MAX_DIGITS-1:0] out_word,
    output logic [2:0]              out_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int W = 4 * MAX_DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_OUT = 2'd1,
        ST_ERR = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   word_q, word_d;
    logic [2:0]     count_q, count_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;
    logic [1:0]     err_code_q, err_code_d;

    logic           is_digit;
    logic           is_cr;
    logic [3:0]     nibble;
    logic           accept;

    always_comb begin
        is_digit = 1'b0;
        is_cr    = 1'b0;
        nibble   = 4'h0;
        if (in_char >= 7'h30 && in_char <= 7'h39) begin
            is_digit = 1'b1;
            nibble   = in_char[3:0];
        end else if (in_char >= 7'h41 && in_char <= 7'h46) begin
            is_digit = 1'b1;
            nibble   = in_char[3:0] + 4'd9;
`ifdef ASCII2HEX_LOWER_EN
        end else if (in_char >= 7'h61 && in_char <= 7'h66) begin
            is_digit = 1'b1;
            nibble   = in_char[3:0] + 4'd9;
`endif
        end else if (in_char == 7'h0D) begin
            is_cr = 1'b1;
        end
    end

    assign in_ready = (state_q != ST_OUT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (is_digit) begin
                        if (count_q < MAX_CNT) begin
                            word_d  = (word_q << 4) | W'(nibble);
                            count_d = count_q + 3'd1;
                        end else begin
                            state_d    = ST_ERR;
                            err_d      = 1'b1;
                            err_code_d = 2'b10;
                        end
                    end else if (is_cr) begin
                        // An empty line produces nothing and stays in ACC.
                        if (count_q != 3'd0) begin
                            state_d     = ST_OUT;
                            out_valid_d = 1'b1;
                        end
                    end else begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_ACC;
                    word_d      = '0;
                    count_d     = 3'd0;
                    out_valid_d = 1'b0;
                end
            end
            ST_ERR: begin
                if (accept && is_cr) begin
                    state_d    = ST_ACC;
                    word_d     = '0;
                    count_d    = 3'd0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                end
            end
            default: begin
                state_d     = ST_ACC;
                word_d      = '0;
                count_d     = 3'd0;
                out_valid_d = 1'b0;
                err_d       = 1'b0;
                err_code_d  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            word_q      <= '0;
            count_q     <= 3'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_valid_q ? word_q : '0;
    assign out_count = out_valid_q ? count_q : 3'd0;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
